// File: rtl/float_conv_pkg.sv
// Shared types and width helpers for the float_conv_seq converter.
// The FLOAT_CONV_ROUND_EN macro is consumed by float_conv_round, not here.
package float_conv_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    NORM  = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  function automatic int exp_max(input int exp_w);
    return (1 << exp_w) - 1;
  endfunction

  function automatic int sig_max(input int sig_w);
    return (1 << sig_w) - 1;
  endfunction

  // The input must fill exactly the significand plus the full shift range.
  function automatic bit in_w_ok(input int in_w, input int exp_w, input int sig_w);
    return in_w == (sig_w + (1 << exp_w));
  endfunction

endpackage

// File: rtl/float_conv_round.sv
// Combinational rounding stage: round-half-up with carry renormalisation.
// Macro FLOAT_CONV_ROUND_EN enables rounding; otherwise the round bit is dropped.
module float_conv_round
  import float_conv_pkg::*;
#(
  parameter int EXP_W = 3,
  parameter int SIG_W = 4
) (
  input  logic [SIG_W-1:0] sig_i,
  input  logic             r_i,
  input  logic [EXP_W-1:0] exp_i,
  output logic [SIG_W-1:0] sig_o,
  output logic [EXP_W-1:0] exp_o,
  output logic             sat_o
);

  localparam int EXP_MAX = exp_max(EXP_W);
  localparam int SIG_MAX = sig_max(SIG_W);

`ifdef FLOAT_CONV_ROUND_EN
  logic [SIG_W:0] sum;

  // Increment on the round bit; a carry either bumps the exponent or clamps.
  always_comb begin
    sum   = {1'b0, sig_i} + {{SIG_W{1'b0}}, r_i};
    sig_o = sum[SIG_W-1:0];
    exp_o = exp_i;
    sat_o = 1'b0;
    if (sum[SIG_W]) begin
      if (exp_i < EXP_W'(EXP_MAX)) begin
        sig_o = {1'b1, {(SIG_W-1){1'b0}}};
        exp_o = exp_i + EXP_W'(1);
      end else begin
        sig_o = SIG_W'(SIG_MAX);
        sat_o = 1'b1;
      end
    end else begin
      sig_o = sum[SIG_W-1:0];
    end
  end
`else
  logic unused_r;

  assign unused_r = r_i;
  assign sig_o    = sig_i;
  assign exp_o    = exp_i;
  assign sat_o    = 1'b0;
`endif

endmodule

// File: rtl/float_conv_seq.sv
// Sequential two's-complement to sig*2^exp converter with valid/ready handshakes.
// Rounding mode selected by macro FLOAT_CONV_ROUND_EN (see float_conv_round).
module float_conv_seq
  import float_conv_pkg::*;
#(
  parameter int EXP_W = 3,
  parameter int SIG_W = 4,
  parameter int IN_W  = SIG_W + (1 << EXP_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IN_W-1:0]  d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sign,
  output logic [EXP_W-1:0] exp,
  output logic [SIG_W-1:0] sig,
  output logic             sat,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int M_W     = IN_W - 1;
  localparam int EXP_MAX = exp_max(EXP_W);

  if (!in_w_ok(IN_W, EXP_W, SIG_W)) begin : g_bad_in_w
    $error("float_conv_seq: IN_W must equal SIG_W + 2**EXP_W");
  end

  state_t           state_q, state_d;
  logic [M_W-1:0]   m_q, m_d;
  logic [EXP_W-1:0] e_q, e_d;
  logic             sign_q, sign_d;
  logic             ovf_q, ovf_d;
  logic [EXP_W-1:0] exp_q, exp_d;
  logic [SIG_W-1:0] sig_q, sig_d;
  logic             sat_q, sat_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;

  logic [IN_W-1:0]  mag;
  logic [SIG_W-1:0] rnd_sig;
  logic [EXP_W-1:0] rnd_exp;
  logic             rnd_sat;

  float_conv_round #(
    .EXP_W (EXP_W),
    .SIG_W (SIG_W)
  ) u_round (
    .sig_i (m_q[M_W-1 -: SIG_W]),
    .r_i   (m_q[M_W-1-SIG_W]),
    .exp_i (e_q),
    .sig_o (rnd_sig),
    .exp_o (rnd_exp),
    .sat_o (rnd_sat)
  );

  // Next-state, normalisation datapath and handshake outputs.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    e_d     = e_q;
    sign_d  = sign_q;
    ovf_d   = ovf_q;
    exp_d   = exp_q;
    sig_d   = sig_q;
    sat_d   = sat_q;
    mag     = d[IN_W-1] ? (~d + IN_W'(1)) : d;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = NORM;
          sign_d  = d[IN_W-1];
          e_d     = EXP_W'(EXP_MAX);
          // Only the most-negative input overflows the magnitude field.
          if (mag[IN_W-1]) begin
            m_d   = {M_W{1'b1}};
            ovf_d = 1'b1;
          end else begin
            m_d   = mag[M_W-1:0];
            ovf_d = 1'b0;
          end
        end else begin
          state_d = IDLE;
        end
      end
      NORM: begin
        if (!m_q[M_W-1] && (e_q != {EXP_W{1'b0}})) begin
          m_d = {m_q[M_W-2:0], 1'b0};
          e_d = e_q - EXP_W'(1);
        end else begin
          state_d = ROUND;
        end
      end
      ROUND: begin
        sig_d   = rnd_sig;
        exp_d   = rnd_exp;
        sat_d   = ovf_q | rnd_sat;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = DONE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      m_q         <= {M_W{1'b0}};
      e_q         <= {EXP_W{1'b0}};
      sign_q      <= 1'b0;
      ovf_q       <= 1'b0;
      exp_q       <= {EXP_W{1'b0}};
      sig_q       <= {SIG_W{1'b0}};
      sat_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      m_q         <= m_d;
      e_q         <= e_d;
      sign_q      <= sign_d;
      ovf_q       <= ovf_d;
      exp_q       <= exp_d;
      sig_q       <= sig_d;
      sat_q       <= sat_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign sign      = sign_q;
  assign exp       = exp_q;
  assign sig       = sig_q;
  assign sat       = sat_q;

endmodule

// File: tb/tb_float_conv_seq.sv
// Randomised self-checking bench for float_conv_seq against an arithmetic reference.
// Expected rounding follows FLOAT_CONV_ROUND_EN as seen by this compilation.
module tb_float_conv_seq;

  localparam int EXP_W = 3;
  localparam int SIG_W = 4;
  localparam int IN_W  = 12;

  logic             clk = 1'b0;
  logic             rst;
  logic [IN_W-1:0]  d;
  logic             in_valid;
  logic             in_ready;
  logic             sign;
  logic [EXP_W-1:0] exp;
  logic [SIG_W-1:0] sig;
  logic             sat;
  logic             out_valid;
  logic             out_ready;

  int n_checks = 0;
  int n_errors = 0;

  float_conv_seq #(
    .EXP_W (EXP_W),
    .SIG_W (SIG_W),
    .IN_W  (IN_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .d         (d),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .sign      (sign),
    .exp       (exp),
    .sig       (sig),
    .sat       (sat),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int got, input int want);
    n_checks++;
    if (got != want) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, want);
    end
  endtask

  // Reference: magnitude, normalise by doubling, take top bits, then round.
  task automatic model(input logic [11:0] din, output int m_sign, output int m_exp,
                       output int m_sig, output int m_sat, output int m_lat);
    int v;
    int mag;
    int e;
`ifdef FLOAT_CONV_ROUND_EN
    int r;
`endif
    v     = din[11] ? int'(din) - 4096 : int'(din);
    mag   = (v < 0) ? -v : v;
    m_sat = 0;
    if (mag > 2047) begin
      mag   = 2047;
      m_sat = 1;
    end
    e = 7;
    while (mag < 1024 && e > 0) begin
      mag = mag * 2;
      e   = e - 1;
    end
    m_lat = (7 - e) + 2;
    m_sig = mag / 128;
`ifdef FLOAT_CONV_ROUND_EN
    r = (mag / 64) % 2;
    if (r == 1) begin
      m_sig = m_sig + 1;
      if (m_sig == 16) begin
        if (e < 7) begin
          m_sig = 8;
          e     = e + 1;
        end else begin
          m_sig = 15;
          m_sat = 1;
        end
      end
    end
`endif
    m_exp  = e;
    m_sign = int'(din[11]);
  endtask

  // Full transaction: accept, measure latency, hold in DONE, then release.
  task automatic convert(input logic [11:0] din, input int hold);
    int  e_sign, e_exp, e_sig, e_sat, e_lat;
    int  cyc;
    bit  seen;
    string t;
    model(din, e_sign, e_exp, e_sig, e_sat, e_lat);
    t = $sformatf("d=%03h", din);
    cyc = 0;
    while (!in_ready && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    check_eq({t, " in_ready_before"}, int'(in_ready), 1);
    d        = din;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    d        = 12'($urandom);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_eq({t, " latency"}, cyc, e_lat);
    check_eq({t, " sign"}, int'(sign), e_sign);
    check_eq({t, " exp"}, int'(exp), e_exp);
    check_eq({t, " sig"}, int'(sig), e_sig);
    check_eq({t, " sat"}, int'(sat), e_sat);
    check_eq({t, " in_ready_busy"}, int'(in_ready), 0);
    for (int i = 0; i < hold; i++) begin
      in_valid = 1'b1;
      d        = 12'($urandom);
      @(posedge clk);
      @(negedge clk);
      check_eq({t, " hold"}, int'({sign, exp, sig, sat, out_valid, in_ready}),
               (e_sign << 10) | (e_exp << 7) | (e_sig << 3) | (e_sat << 2) | 2);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({t, " release"}, int'({sign, exp, sig, sat, out_valid, in_ready}),
             (e_sign << 10) | (e_exp << 7) | (e_sig << 3) | (e_sat << 2) | 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bit seen;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    d         = 12'h000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("reset", int'({sign, exp, sig, sat, out_valid, in_ready}), 1);
    rst = 1'b0;
    @(negedge clk);

    convert(12'h800, 0);
    convert(12'h7FF, 1);
    convert(12'h001, 0);
    convert(12'd62, 0);
    convert(12'd47, 2);
    convert(12'h000, 0);
    convert(12'hA5C, 5);

    // Abort a conversion of 1 while it is still normalising.
    d        = 12'h001;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check_eq("abort_state", int'({sign, exp, sig, sat, out_valid, in_ready}), 1);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    check_eq("abort_no_output", int'(seen), 0);
    convert(12'hFFF, 0);

    for (int i = 0; i < 40; i++) begin
      convert(12'($urandom), int'($urandom_range(0, 3)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/float_conv_seq.md
FLOAT_CONV_SEQ -- requirements
Module: float_conv_seq

Interface
REQ-001 The block SHALL use one clock and a synchronous, active-high reset.
REQ-002 Parameter EXP_W SHALL default to 3 and set the exponent width.
REQ-003 Parameter SIG_W SHALL default to 4 and set the significand width.
REQ-004 Parameter IN_W SHALL equal SIG_W + 2**EXP_W (default 12) and set the input width; any other value is an elaboration error.
REQ-005 Port clk SHALL be an input, 1 bit wide, and is the rising-edge clock.
REQ-006 Port rst SHALL be an input, 1 bit wide, and is the synchronous active-high reset.
REQ-007 Port d SHALL be an input, IN_W bits wide, carrying a two's-complement sample.
REQ-008 Port in_valid SHALL be an input, 1 bit wide, indicating that d is valid.
REQ-009 Port in_ready SHALL be an output, 1 bit wide, indicating that the block can accept d.
REQ-010 Port sign SHALL be an output, 1 bit wide, carrying the result sign.
REQ-011 Port exp SHALL be an output, EXP_W bits wide, carrying the result exponent.
REQ-012 Port sig SHALL be an output, SIG_W bits wide, carrying the result significand; value = sig * 2^exp.
REQ-013 Port sat SHALL be an output, 1 bit wide, flagging that the result was clamped.
REQ-014 Port out_valid SHALL be an output, 1 bit wide, indicating that the result is valid.
REQ-015 Port out_ready SHALL be an input, 1 bit wide, indicating that downstream accepts the result.

Function
REQ-016 The FSM SHALL have four states, IDLE, NORM, ROUND and DONE; in_ready SHALL equal 1 only in IDLE, and out_valid SHALL equal 1 only in DONE.
REQ-017 In IDLE, when in_valid=1, the block SHALL latch the following and enter NORM:
- sign = d[IN_W-1];
- magnitude m = |d| held in IN_W-1 bits;
- exp = 2**EXP_W-1.
REQ-018 An input of d = most-negative (12'h800 at default widths) SHALL produce m = 2**(IN_W-1)-1 and SHALL set sat.
REQ-019 In NORM, on each cycle where m[IN_W-2]=0 and exp>0, the block SHALL shift m left by 1 (filling with zero) and decrement exp; otherwise it SHALL go to ROUND.
- NORM therefore lasts k+1 cycles, where k is the shift count, 0..2**EXP_W-1.
REQ-020 In ROUND, the block SHALL take sig = m[IN_W-2 -: SIG_W] and round bit r = m[IN_W-2-SIG_W], then enter DONE.
REQ-021 The rounding increment SHALL be as follows:
- If r=1 (round enabled), sig SHALL be incremented.
- On carry-out with exp<max, the result SHALL be sig = 1000...0 and exp = exp+1.
- On carry-out with exp=max, the result SHALL be sig = all-ones and sat=1.
REQ-022 In DONE, the outputs SHALL hold stable while out_ready=0; when out_ready=1, the block SHALL return to IDLE.
- in_ready SHALL return to 1 on the next cycle, so there is no same-cycle re-accept.
REQ-023 out_valid SHALL rise k+2 cycles after the accepting clock edge.
REQ-024 in_valid and d SHALL be ignored outside IDLE.
REQ-025 A zero input SHALL give sign=0, exp=0, sig=0 and sat=0 after 2**EXP_W-1 shifts.

Reset
REQ-026 When rst=1 at a clock edge, the block SHALL enter IDLE with sign=0, exp=0, sig=0, sat=0, out_valid=0 and in_ready=1.
REQ-027 Reset SHALL abort any in-flight conversion in any state without producing output.

Configuration
REQ-028 Macro FLOAT_CONV_ROUND_EN SHALL select the rounding mode:
- Defined: round-half-up on magnitude per REQ-021.
- Undefined: r is ignored (truncation), and sat is set only by REQ-018.
- Latency SHALL be identical in both modes.

Structure
REQ-029 Package float_conv_pkg SHALL hold the state enum, the EXP_MAX/SIG_MAX derivation functions and the IN_W legality check.
REQ-030 Sub-module float_conv_round SHALL be combinational, taking {sig, r, exp} and producing {sig, exp, sat} per REQ-021/REQ-028; the FSM and datapath SHALL live in float_conv_seq.

Verification (default params, FLOAT_CONV_ROUND_EN defined unless stated)
REQ-031 The bench SHALL cover d = 12'h800 -> sign=1, exp=7, sig=4'b1111, sat=1, out_valid 2 cycles after accept.
REQ-032 The bench SHALL cover d = 12'h7FF -> sign=0, exp=7, sig=4'b1111, sat=1; with the macro undefined, the same values but sat=0.
REQ-033 The bench SHALL cover d = 12'h001 -> sign=0, exp=0, sig=4'b0001, sat=0, out_valid 9 cycles after accept.
REQ-034 The bench SHALL cover d = 12'd62 -> exp=3, sig=4'b1000 (carry renormalise); d = 12'd47 -> exp=2, sig=4'b1100.
REQ-035 The bench SHALL cover out_ready held 0 for 5 cycles in DONE with in_valid=1 and new d -> outputs unchanged, in_ready=0, and the new d is not captured.
REQ-036 The bench SHALL cover rst=1 during the NORM state of d=12'h001 -> IDLE next cycle, out_valid never asserts, and a following d=12'hFFF yields sign=1, exp=0, sig=4'b0001.
